// File: rtl/inst_queue_if.sv
// Fetch-to-ID instruction queue bundle: enqueue side, dequeue side, flush and status.
// The queue takes the slave view; the fetch/backend environment takes the master view.
interface inst_queue_if #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned IW    = 32,
  parameter int unsigned PCW   = 32
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic           flush;
  logic           enq_valid;
  logic           enq_ready;
  logic [IW-1:0]  enq_inst;
  logic [PCW-1:0] enq_pc;
  logic           enq_pred_taken;
  logic           deq_valid;
  logic           deq_ready;
  logic [IW-1:0]  deq_inst;
  logic [PCW-1:0] deq_pc;
  logic           deq_pred_taken;
  logic [CW-1:0]  count;
  logic           full;
  logic           empty;

  modport master (
    output flush, enq_valid, enq_inst, enq_pc, enq_pred_taken, deq_ready,
    input  enq_ready, deq_valid, deq_inst, deq_pc, deq_pred_taken, count, full, empty
  );

  modport slave (
    input  flush, enq_valid, enq_inst, enq_pc, enq_pred_taken, deq_ready,
    output enq_ready, deq_valid, deq_inst, deq_pc, deq_pred_taken, count, full, empty
  );
endinterface

// File: rtl/inst_queue.sv
// Circular instruction queue decoupling fetch from ID; wrap-bit pointers,
// combinational head read, flush empties by snapping rptr to wptr.
module inst_queue #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned IW    = 32,
  parameter int unsigned PCW   = 32
) (
  input logic         clk,
  input logic         rst,
  inst_queue_if.slave q
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  typedef struct packed {
    logic [IW-1:0]  inst;
    logic [PCW-1:0] pc;
    logic           pred_taken;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic          full_c;
  logic          empty_c;
  logic          enq_fire;
  logic          deq_fire;
  entry_t        head;

  // Same index with opposite wrap bits means the writer is a full lap ahead.
  assign empty_c  = (wptr == rptr);
  assign full_c   = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
  assign enq_fire = q.enq_valid && q.enq_ready;
  assign deq_fire = q.deq_valid && q.deq_ready;
  assign head     = mem[rptr[AW-1:0]];

  assign q.enq_ready      = !full_c && !q.flush;
  assign q.deq_valid      = !empty_c;
  assign q.deq_inst       = head.inst;
  assign q.deq_pc         = head.pc;
  assign q.deq_pred_taken = head.pred_taken;
  assign q.count          = wptr - rptr;
  assign q.full           = full_c;
  assign q.empty          = empty_c;

  // Payload storage needs no reset; occupancy is governed by the pointers.
  always_ff @(posedge clk) begin
    if (rst && enq_fire) begin
      mem[wptr[AW-1:0]] <= '{inst: q.enq_inst, pc: q.enq_pc, pred_taken: q.enq_pred_taken};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
    end else if (q.flush) begin
      rptr <= wptr;
    end else begin
      if (enq_fire) wptr <= wptr + PW'(1);
      if (deq_fire) rptr <= rptr + PW'(1);
    end
  end

  a_no_enq_full:  assert property (@(posedge clk) disable iff (!rst) !(enq_fire && full_c));
  a_no_deq_empty: assert property (@(posedge clk) disable iff (!rst) !(deq_fire && empty_c));
  a_count_bound:  assert property (@(posedge clk) disable iff (!rst) (32'(q.count) <= DEPTH));
endmodule
